// File: rtl/ram_dual_port_pkg.sv
// Shared types and helpers for the dual-port word RAM and its users.
package ram_dual_port_pkg;

    typedef enum logic {
        CLEARING = 1'b0,
        IDLE     = 1'b1
    } ram_clear_state_e;

    // Number of byte-offset bits dropped from a byte address to form a word index.
    function automatic int unsigned word_address_size(input int unsigned word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/ram_byte_lane_merge.sv
// Merges a new word into an old word lane by lane under a byte mask.
module ram_byte_lane_merge #(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic [8*WORD_BYTES-1:0] old_word,
    input  logic [8*WORD_BYTES-1:0] new_word,
    input  logic [WORD_BYTES-1:0]   byte_enable,
    output logic [8*WORD_BYTES-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (byte_enable[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_dual_port.sv
// Word RAM with a read-only fetch port, a byte-maskable data port and a
// hardware clear sweep that holds both ports inert while it runs.
module ram_dual_port
    import ram_dual_port_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = 12,
    parameter int unsigned          WORD_BYTES  = 4,
    parameter logic [8*WORD_BYTES-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    output logic                    busy,
    input  logic [ADDR_WIDTH-1:0]   f_address,
    output logic [8*WORD_BYTES-1:0] f_out,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic                    d_write_enable,
    input  logic [WORD_BYTES-1:0]   d_byte_enable,
    input  logic [8*WORD_BYTES-1:0] d_in,
    output logic [8*WORD_BYTES-1:0] d_out
);

    localparam int unsigned WORD_ADDRESS_SIZE = word_address_size(WORD_BYTES);
    localparam int unsigned INDEX_WIDTH       = ADDR_WIDTH - WORD_ADDRESS_SIZE;
    localparam int unsigned DEPTH             = 1 << INDEX_WIDTH;
    localparam int unsigned DATA_WIDTH        = 8 * WORD_BYTES;

    logic [DATA_WIDTH-1:0] memory [DEPTH];

    ram_clear_state_e       state_q, state_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;

    logic                   mem_we;
    logic [INDEX_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    logic [INDEX_WIDTH-1:0] f_word, d_word;
    logic [DATA_WIDTH-1:0]  f_rdata, d_rdata, d_merged;

    assign f_word  = f_address[ADDR_WIDTH-1:WORD_ADDRESS_SIZE];
    assign d_word  = d_address[ADDR_WIDTH-1:WORD_ADDRESS_SIZE];
    assign f_rdata = memory[f_word];
    assign d_rdata = memory[d_word];

    // Byte offset bits carry no information for word-granular access.
    if (WORD_ADDRESS_SIZE > 0) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^{f_address[WORD_ADDRESS_SIZE-1:0],
                                   d_address[WORD_ADDRESS_SIZE-1:0]};
    end

    ram_byte_lane_merge #(
        .WORD_BYTES (WORD_BYTES)
    ) u_merge (
        .old_word    (d_rdata),
        .new_word    (d_in),
        .byte_enable (d_byte_enable),
        .merged      (d_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEARING;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Sweep sequencing and selection of the single array write port.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        mem_we    = 1'b0;
        mem_waddr = d_word;
        mem_wdata = d_merged;
        unique case (state_q)
            CLEARING: begin
                mem_we    = 1'b1;
                mem_waddr = index_q;
                mem_wdata = CLEAR_VALUE;
                if (index_q == INDEX_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    index_d = '0;
                end else begin
                    index_d = index_q + INDEX_WIDTH'(1);
                end
            end
            IDLE: begin
                mem_we = d_write_enable;
                if (clear) begin
                    state_d = CLEARING;
                    index_d = '0;
                end
            end
            default: begin
                state_d = CLEARING;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            memory[mem_waddr] <= mem_wdata;
        end
    end

    assign busy  = (state_q == CLEARING);
    assign f_out = busy ? '0 : f_rdata;
    assign d_out = busy ? '0 : d_rdata;

endmodule

// File: tb/tb_ram_dual_port.sv
// Scenario bench for ram_dual_port with a scoreboard of expected read values.
module tb_ram_dual_port;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        busy;
    logic [11:0] f_address;
    logic [31:0] f_out;
    logic [11:0] d_address;
    logic        d_write_enable;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_in;
    logic [31:0] d_out;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dual_port dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .busy           (busy),
        .f_address      (f_address),
        .f_out          (f_out),
        .d_address      (d_address),
        .d_write_enable (d_write_enable),
        .d_byte_enable  (d_byte_enable),
        .d_in           (d_in),
        .d_out          (d_out)
    );

    function automatic sb_entry_t mk(input logic [11:0] a, input logic [31:0] d);
        sb_entry_t x;
        x.addr = a;
        x.data = d;
        return x;
    endfunction

    // One data-port write with optional clear, applied at the next posedge.
    task automatic drive_write(input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic clr);
        d_address      = a;
        d_in           = d;
        d_byte_enable  = be;
        d_write_enable = 1'b1;
        clear          = clr;
        @(posedge clk); #1;
        d_write_enable = 1'b0;
        clear          = 1'b0;
    endtask

    // Counts sampled busy cycles, optionally injecting a write or a clear.
    task automatic count_busy(input int write_at, input int clear_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            n++;
            if (n == write_at) begin
                d_address      = 12'h008;
                d_in           = 32'h12345678;
                d_byte_enable  = 4'hF;
                d_write_enable = 1'b1;
            end
            if (n == clear_at) clear = 1'b1;
            @(posedge clk); #1;
            d_write_enable = 1'b0;
            clear          = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] dv, fv;
        reset = 1'b0; clear = 1'b0; d_write_enable = 1'b0;
        d_byte_enable = 4'h0; d_in = '0; d_address = '0; f_address = 12'h020;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++;
        if (f_out !== 32'h0) begin errors++; $display("FAIL reset_fout: got %h expected 00000000", f_out); end
        #2 reset = 1'b1;
        count_busy(0, 0, n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL reset_sweep_len: got %0d expected %0d", n, DEPTH); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            d_address = 12'(i * 4);
            f_address = 12'(i * 4 + 3);
            #1;
            dv = d_out;
            fv = f_out;
            checks++;
            if (dv !== 32'h0 || fv !== 32'h0) begin
                errors++;
                $display("FAIL reset_word_%0d: got d=%h f=%h expected 00000000", i, dv, fv);
            end
        end
    endtask

    task automatic test_full_write();
        d_address = 12'h010; f_address = 12'h010;
        d_in = 32'hDEADBEEF; d_byte_enable = 4'hF; d_write_enable = 1'b1;
        #1;
        checks++;
        if (d_out !== 32'h0 || f_out !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_old: got d=%h f=%h expected 00000000", d_out, f_out);
        end
        @(posedge clk); #1;
        d_write_enable = 1'b0;
        sb.push_back(mk(12'h010, 32'hDEADBEEF));
        sb.push_back(mk(12'h011, 32'hDEADBEEF));
        sb.push_back(mk(12'h013, 32'hDEADBEEF));
        drive_write(12'hFFC, 32'hCAFEF00D, 4'hF, 1'b0);
        sb.push_back(mk(12'hFFF, 32'hCAFEF00D));
        sb.push_back(mk(12'h014, 32'h0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d_address = e.addr; f_address = e.addr; #1;
            checks++;
            if (d_out !== e.data || f_out !== e.data) begin
                errors++;
                $display("FAIL full_write@%h: got d=%h f=%h expected %h", e.addr, d_out, f_out, e.data);
            end
        end
    endtask

    task automatic test_partial_write();
        drive_write(12'h020, 32'h11223344, 4'hF, 1'b0);
        drive_write(12'h020, 32'hAABBCCDD, 4'b0101, 1'b0);
        sb.push_back(mk(12'h020, 32'h11BB33DD));
        drive_write(12'h020, 32'hFFFFFFFF, 4'b0000, 1'b0);
        sb.push_back(mk(12'h021, 32'h11BB33DD));
        drive_write(12'h024, 32'h99887766, 4'b1010, 1'b0);
        sb.push_back(mk(12'h024, 32'h99007700));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d_address = e.addr; f_address = e.addr; #1;
            checks++;
            if (d_out !== e.data || f_out !== e.data) begin
                errors++;
                $display("FAIL partial_write@%h: got d=%h f=%h expected %h", e.addr, d_out, f_out, e.data);
            end
        end
    endtask

    task automatic test_write_during_sweep();
        int n;
        clear = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_comb_path: got %b expected 0", busy); end
        @(posedge clk); #1;
        clear = 1'b0;
        f_address = 12'h020; d_address = 12'h010; #1;
        checks++;
        if (f_out !== 32'h0 || d_out !== 32'h0) begin
            errors++;
            $display("FAIL busy_reads_zero: got f=%h d=%h expected 00000000", f_out, d_out);
        end
        count_busy(2, 500, n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL sweep_len_with_clear: got %0d expected %0d", n, DEPTH); end
        sb.push_back(mk(12'h008, 32'h0));
        sb.push_back(mk(12'h020, 32'h0));
        sb.push_back(mk(12'hFFC, 32'h0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d_address = e.addr; f_address = e.addr; #1;
            checks++;
            if (d_out !== e.data || f_out !== e.data) begin
                errors++;
                $display("FAIL blocked_write@%h: got d=%h f=%h expected %h", e.addr, d_out, f_out, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        drive_write(12'h004, 32'h00000055, 4'hF, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_clear_busy: got %b expected 1", busy); end
        count_busy(0, 0, n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL wr_clear_sweep_len: got %0d expected %0d", n, DEPTH); end
        sb.push_back(mk(12'h004, 32'h0));
        drive_write(12'h030, 32'h0BADF00D, 4'hF, 1'b0);
        sb.push_back(mk(12'h030, 32'h0BADF00D));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d_address = e.addr; f_address = e.addr; #1;
            checks++;
            if (d_out !== e.data || f_out !== e.data) begin
                errors++;
                $display("FAIL back_to_back@%h: got d=%h f=%h expected %h", e.addr, d_out, f_out, e.data);
            end
        end
    endtask

    task automatic test_async_reset_mid_sweep();
        int n;
        drive_write(12'h000, 32'h0, 4'h0, 1'b1);
        repeat (100) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: got %b expected 1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL async_reset_busy: got %b expected 1", busy); end
        #2 reset = 1'b1;
        count_busy(0, 0, n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL restart_sweep_len: got %0d expected %0d", n, DEPTH); end
        sb.push_back(mk(12'h030, 32'h0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d_address = e.addr; f_address = e.addr; #1;
            checks++;
            if (d_out !== e.data || f_out !== e.data) begin
                errors++;
                $display("FAIL after_reset@%h: got d=%h f=%h expected %h", e.addr, d_out, f_out, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_full_write();
        @(posedge clk); #1;
        test_partial_write();
        @(posedge clk); #1;
        test_write_during_sweep();
        @(posedge clk); #1;
        test_back_to_back();
        @(posedge clk); #1;
        test_async_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
